// File: rtl/gtxe2_chnl_rx_pkg.sv
// Shared constants for the GTXE2 RX channel model: K28.5 comma patterns
// (bit 0 received first) and the comma length.
package gtxe2_chnl_rx_pkg;
  localparam int                   COMMA_LEN = 10;
  localparam logic [COMMA_LEN-1:0] K28_5_P   = 10'b0101111100;
  localparam logic [COMMA_LEN-1:0] K28_5_M   = 10'b1010000011;
endpackage

// File: rtl/gtxe2_chnl_rx_comma_det.sv
// 10-bit window compare against the plus/minus comma patterns.
// The outputs are combinational, so the caller registers them if needed.
module gtxe2_chnl_rx_comma_det
  import gtxe2_chnl_rx_pkg::*;
#(
  parameter logic [COMMA_LEN-1:0] pcomma = K28_5_P,
  parameter logic [COMMA_LEN-1:0] mcomma = K28_5_M
) (
  input  logic [COMMA_LEN-1:0] win,
  output logic                 pmatch,
  output logic                 mmatch
);
  assign pmatch = (win == pcomma);
  assign mmatch = (win == mcomma);
endmodule

// File: rtl/gtxe2_chnl_rx_des_align.sv
// Serial-to-parallel deserializer with K28.5 comma alignment and manual slip.
// Collects one bit per inclk into width (or width*4/5 when trimmed) bit words.
module gtxe2_chnl_rx_des_align
  import gtxe2_chnl_rx_pkg::*;
#(
  parameter int                   width     = 20,
  parameter logic [COMMA_LEN-1:0] pcomma    = K28_5_P,
  parameter logic [COMMA_LEN-1:0] mcomma    = K28_5_M,
  parameter int                   align_cnt = 3
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic             indata,
  input  logic             trim,
  input  logic             comma_en,
  input  logic             slip,
  output logic [width-1:0] outdata,
  output logic             outvalid,
  output logic             comma_det,
  output logic             realign,
  output logic             byte_aligned
);
  localparam int TW = width * 4 / 5;
  localparam int CW = $clog2(width) + 1;

  // History register, newest bit at the top: a word is {indata, history}.
  logic [width-2:0]     sr;
  logic [CW-1:0]        cnt, cnt_nxt, we_m1;
  logic [3:0]           acnt, acnt_inc;
  logic                 slip_taken, slip_nxt;
  logic                 ce, pm, mm, match, aligned, mis, emit;
  logic [COMMA_LEN-1:0] win;
  logic [width-1:0]     word;

  assign we_m1    = trim ? CW'(TW - 1) : CW'(width - 1);
  assign ce       = comma_en & ~trim;
  assign win      = {indata, sr[width-2 -: COMMA_LEN-1]};
  assign match    = ce & (pm | mm);
  assign aligned  = match & ((cnt % CW'(COMMA_LEN)) == CW'(COMMA_LEN - 1));
  assign mis      = match & ~aligned;
  assign acnt_inc = (acnt < 4'(align_cnt)) ? acnt + 4'd1 : acnt;

  gtxe2_chnl_rx_comma_det #(
    .pcomma (pcomma),
    .mcomma (mcomma)
  ) u_comma (
    .win    (win),
    .pmatch (pm),
    .mmatch (mm)
  );

  always_comb begin
    word = '0;
    if (trim) word[TW-1:0] = {indata, sr[width-2 -: TW-1]};
    else      word         = {indata, sr};
  end

  // Boundary control: realign beats slip beats normal counting.
  always_comb begin
    cnt_nxt  = cnt;
    slip_nxt = slip_taken;
    emit     = 1'b0;
    if (mis) begin
      cnt_nxt = CW'(COMMA_LEN);
    end else if (cnt > we_m1) begin
      // trim narrowed the word under us; drop the partial word
      cnt_nxt = '0;
    end else if (slip && !ce && !slip_taken) begin
      slip_nxt = 1'b1;
    end else if (cnt == we_m1) begin
      emit     = 1'b1;
      cnt_nxt  = '0;
      slip_nxt = 1'b0;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      sr           <= '0;
      cnt          <= '0;
      acnt         <= '0;
      slip_taken   <= 1'b0;
      outdata      <= '0;
      outvalid     <= 1'b0;
      comma_det    <= 1'b0;
      realign      <= 1'b0;
      byte_aligned <= 1'b0;
    end else begin
      sr         <= {indata, sr[width-2:1]};
      cnt        <= cnt_nxt;
      slip_taken <= slip_nxt;
      outvalid   <= emit;
      comma_det  <= match;
      realign    <= mis;
      if (emit) outdata <= word;
      if (mis) begin
        acnt         <= '0;
        byte_aligned <= 1'b0;
      end else if (aligned) begin
        acnt <= acnt_inc;
        if (acnt_inc == 4'(align_cnt)) byte_aligned <= 1'b1;
      end
    end
  end
endmodule
